// File: rtl/fp_mult_scheduler_if.sv
// Request/response bundle for the shared FP multiplier scheduler.
// master = issue/writeback side, slave = the scheduler itself.
interface fp_mult_scheduler_if #(
   parameter int TAG_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_a;
   logic [31:0]      req0_b;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_a;
   logic [31:0]      req1_b;
   logic [TAG_W-1:0] req1_tag;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_result;
   logic             resp_port;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_special;

   modport master (
      output req0_valid, req0_a, req0_b, req0_tag,
      output req1_valid, req1_a, req1_b, req1_tag,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_result, resp_port,
      input  resp_tag, resp_special
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_tag,
      input  req1_valid, req1_a, req1_b, req1_tag,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_result, resp_port,
      output resp_tag, resp_special
   );
endinterface

// File: rtl/fp_mult_scheduler.sv
// Two-port round-robin scheduler around one shared
// single-precision multiplier core, 2-stage pipeline.

module normal_mult (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);
   logic [24:0] prod_hi;
   logic [7:0]  exp_r;
   logic [22:0] frac;

   // Truncating significand product; exponent wraps mod 256.
   always_comb begin
      prod_hi = 25'((48'({1'b1, a_i[22:0]})
                   * 48'({1'b1, b_i[22:0]})) >> 23);
      exp_r = a_i[30:23] + b_i[30:23] - 8'd127
            + {7'd0, prod_hi[24]};
      frac = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
      p_o = {a_i[31] ^ b_i[31], exp_r, frac};
   end
endmodule

module fp_mult_scheduler #(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   fp_mult_scheduler_if.slave  bus,
   output logic                busy,
   output logic [15:0]         op_count
);
   typedef struct packed {
      logic [31:0]      a;
      logic [31:0]      b;
      logic             port;
      logic [TAG_W-1:0] tag;
   } s1_t;

   logic             s1_valid_q, s1_valid_d;
   s1_t              s1_q, s1_d;
   logic             rv_q, rv_d;
   logic [31:0]      rres_q, rres_d;
   logic             rport_q, rport_d;
   logic [TAG_W-1:0] rtag_q, rtag_d;
   logic             rspec_q, rspec_d;
   logic             prio_q, prio_d;
   logic [15:0]      cnt_q, cnt_d;

   logic             s1_adv, s2_adv;
   logic             gnt0, gnt1;
   logic [31:0]      core_p;
   logic             zero_op;

   normal_mult u_core (
      .a_i (s1_q.a),
      .b_i (s1_q.b),
      .p_o (core_p)
   );

   // Stage enables and round-robin grant.
   always_comb begin
      s2_adv = !rv_q || bus.resp_ready;
      s1_adv = !s1_valid_q || s2_adv;
      gnt0 = rst_n && s1_adv && bus.req0_valid
           && (!bus.req1_valid || !prio_q);
      gnt1 = rst_n && s1_adv && bus.req1_valid
           && (!bus.req0_valid || prio_q);
      prio_d = prio_q;
      if (gnt0 && bus.req1_valid)
         prio_d = 1'b1;
      else if (gnt1 && bus.req0_valid)
         prio_d = 1'b0;
   end

   // S1 load from the granted requester.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d = s1_q;
      if (s1_adv) begin
         s1_valid_d = gnt0 || gnt1;
         unique case (1'b1)
            gnt0: s1_d = '{bus.req0_a, bus.req0_b,
                           1'b0, bus.req0_tag};
            gnt1: s1_d = '{bus.req1_a, bus.req1_b,
                           1'b1, bus.req1_tag};
            default: ;
         endcase
      end
   end

   // S2 load: zero bypass, special flag, response counter.
   always_comb begin
      zero_op = (s1_q.a[30:23] == 8'h00)
             || (s1_q.b[30:23] == 8'h00);
      rv_d = rv_q;
      rres_d = rres_q;
      rport_d = rport_q;
      rtag_d = rtag_q;
      rspec_d = rspec_q;
      if (s2_adv) begin
         rv_d = s1_valid_q;
         if (s1_valid_q) begin
            rres_d = zero_op
                   ? {s1_q.a[31] ^ s1_q.b[31], 31'b0}
                   : core_p;
            rport_d = s1_q.port;
            rtag_d = s1_q.tag;
            rspec_d = (s1_q.a[30:23] == 8'hFF)
                   || (s1_q.b[30:23] == 8'hFF);
         end
      end
      cnt_d = cnt_q + {15'd0, rv_q && bus.resp_ready};
   end

   // Pipeline, pointer and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q <= '0;
         rv_q <= 1'b0;
         rres_q <= '0;
         rport_q <= 1'b0;
         rtag_q <= '0;
         rspec_q <= 1'b0;
         prio_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q <= s1_d;
         rv_q <= rv_d;
         rres_q <= rres_d;
         rport_q <= rport_d;
         rtag_q <= rtag_d;
         rspec_q <= rspec_d;
         prio_q <= prio_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.resp_valid = rv_q;
   assign bus.resp_result = rres_q;
   assign bus.resp_port = rport_q;
   assign bus.resp_tag = rtag_q;
   assign bus.resp_special = rspec_q;
   assign busy = s1_valid_q || rv_q;
   assign op_count = cnt_q;
endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Scoreboard bench for fp_mult_scheduler: random and
// directed traffic checked against a real-arithmetic model.
module tb_fp_mult_scheduler;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_mult_scheduler_if #(.TAG_W(TAG_W)) bus ();
   logic        busy;
   logic [15:0] op_count;

   fp_mult_scheduler #(.TAG_W(TAG_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   logic             v [2];
   logic [31:0]      a [2];
   logic [31:0]      b [2];
   logic [TAG_W-1:0] t [2];
   logic             rr;

   assign bus.req0_valid = v[0];
   assign bus.req0_a = a[0];
   assign bus.req0_b = b[0];
   assign bus.req0_tag = t[0];
   assign bus.req1_valid = v[1];
   assign bus.req1_a = a[1];
   assign bus.req1_b = b[1];
   assign bus.req1_tag = t[1];
   assign bus.resp_ready = rr;

   typedef struct {
      logic [31:0]      res;
      logic             port;
      logic [TAG_W-1:0] tag;
      logic             spec;
      int               cyc;
   } exp_t;

   exp_t        exp_q [$];
   int          grant_log [$];
   int          resp_cyc [$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          tb_prio = 0;
   logic [15:0] done_cnt = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Product from real-valued significands (exact in double).
   function automatic logic [31:0] model(input logic [31:0] x,
                                         input logic [31:0] y);
      real ma, mb, m;
      int  e, fr;
      logic [7:0] eb;
      if (x[30:23] == 8'h00 || y[30:23] == 8'h00)
         return {x[31] ^ y[31], 31'b0};
      ma = 1.0 + real'(x[22:0]) / 8388608.0;
      mb = 1.0 + real'(y[22:0]) / 8388608.0;
      m = ma * mb;
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (m >= 2.0) begin
         m = m / 2.0;
         e = e + 1;
      end
      fr = $rtoi((m - 1.0) * 8388608.0);
      eb = 8'(e);
      return {x[31] ^ y[31], eb, 23'(fr)};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0] e;
      int k;
      k = $urandom_range(0, 9);
      if (k == 0) e = 8'h00;
      else if (k == 1) e = 8'hFF;
      else e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   // Acceptance observer: scoreboard push and arbitration rule.
   logic rdy [2];
   exp_t ex;
   always @(negedge clk) begin
      if (rst_n) begin
         rdy[0] = bus.req0_ready;
         rdy[1] = bus.req1_ready;
         if (rdy[0] || rdy[1])
            chk("one_ready", rdy[0] && rdy[1], 0);
         for (int p = 0; p < 2; p++) begin
            if (rdy[p]) begin
               chk("ready_valid", v[p], 1);
               if (v[0] && v[1]) begin
                  chk("rr_grant", p, tb_prio);
                  tb_prio = (p == 0) ? 1 : 0;
               end
               ex.res = model(a[p], b[p]);
               ex.port = 1'(p);
               ex.tag = t[p];
               ex.spec = (a[p][30:23] == 8'hFF)
                      || (b[p][30:23] == 8'hFF);
               ex.cyc = cyc;
               exp_q.push_back(ex);
               grant_log.push_back(p);
               n_acc++;
            end
         end
      end
   end

   // Response monitor: pop/compare, hold stability, op_count.
   logic        held = 1'b0;
   logic [37:0] held_val;
   logic [37:0] cur;
   exp_t        ep;
   always @(negedge clk) begin
      cur = {bus.resp_result, bus.resp_port,
             bus.resp_tag, bus.resp_special};
      if (rst_n && bus.resp_valid) begin
         if (held) chk("hold_stable", cur, held_val);
         if (rr) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_resp: got %0h expected none",
                        cur);
            end else begin
               ep = exp_q.pop_front();
               chk("resp", cur,
                   {ep.res, ep.port, ep.tag, ep.spec});
               chk("latency_min", (cyc - ep.cyc) >= 2, 1);
            end
            chk("op_count", op_count, done_cnt);
            done_cnt = done_cnt + 16'd1;
            resp_cyc.push_back(cyc);
         end else begin
            held = 1'b1;
            held_val = cur;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic send(input int p, input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [TAG_W-1:0] tg);
      int w = 0;
      logic got;
      v[p] = 1'b1;
      a[p] = x;
      b[p] = y;
      t[p] = tg;
      forever begin
         @(negedge clk);
         got = (p == 0) ? bus.req0_ready : bus.req1_ready;
         if (got || w > 300) break;
         w++;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: port %0d got no ready expected ready",
                  p);
      end
      @(posedge clk);
      #1;
      v[p] = 1'b0;
   endtask

   task automatic stream(input int p, input int n, input int gmax);
      for (int i = 0; i < n; i++) begin
         send(p, rand_op(), rand_op(), TAG_W'($urandom));
         repeat ($urandom_range(0, gmax)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic one(input int p, input logic [31:0] x,
                      input logic [31:0] y,
                      input logic [TAG_W-1:0] tg,
                      input logic [31:0] er, input logic es);
      send(p, x, y, tg);
      @(negedge clk);
      chk("dir_early", bus.resp_valid, 0);
      @(negedge clk);
      chk("dir_valid", bus.resp_valid, 1);
      chk("dir_result", bus.resp_result, er);
      chk("dir_port", bus.resp_port, p);
      chk("dir_tag", bus.resp_tag, tg);
      chk("dir_special", bus.resp_special, es);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((exp_q.size() != 0 || busy) && w < 300) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain", (exp_q.size() == 0) && !busy, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   int   base, nfill;
   logic sd [2];

   initial begin
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b0;
         a[p] = '0;
         b[p] = '0;
         t[p] = '0;
      end
      rr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      v[0] = 1'b1;
      v[1] = 1'b1;
      #1;
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_result", bus.resp_result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      v[0] = 1'b0;
      v[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rr = 1'b1;

      one(0, 32'h40000000, 32'h40400000, 4'd3,
          32'h40C00000, 1'b0);
      chk("op_count_one", op_count, 1);
      one(1, 32'h3FC00000, 32'h3FC00000, 4'd7,
          32'h40100000, 1'b0);
      one(0, 32'h00000000, 32'hC0000000, 4'd5,
          32'h80000000, 1'b0);
      one(1, 32'h7F800000, 32'h3F800000, 4'd9,
          32'h7F800000, 1'b1);

      grant_log.delete();
      resp_cyc.delete();
      fork
         stream(0, 4, 0);
         stream(1, 4, 0);
      join
      wait_drain();
      chk("cont_count", grant_log.size(), 8);
      for (int i = 0; i < grant_log.size(); i++)
         chk("cont_alt", grant_log[i], i % 2);
      if (resp_cyc.size() == 8)
         chk("cont_b2b", resp_cyc[7] - resp_cyc[0], 7);
      else
         chk("cont_resp_n", resp_cyc.size(), 8);

      rr = 1'b0;
      base = n_acc;
      sd[0] = 1'b0;
      fork
         begin
            stream(0, 4, 0);
            sd[0] = 1'b1;
         end
      join_none
      repeat (8) @(negedge clk);
      chk("bp_accepted", n_acc - base, 2);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", bus.req0_ready, 0);
      @(posedge clk);
      #1;
      rr = 1'b1;
      for (int w = 0; w < 100 && !sd[0]; w++) begin
         @(posedge clk);
         #1;
      end
      chk("bp_done", sd[0], 1);
      wait_drain();
      chk("bp_total", n_acc - base, 4);

      sd[0] = 1'b0;
      sd[1] = 1'b0;
      fork
         begin
            stream(0, 150, 3);
            sd[0] = 1'b1;
         end
         begin
            stream(1, 150, 3);
            sd[1] = 1'b1;
         end
         begin
            while (!(sd[0] && sd[1])) begin
               @(posedge clk);
               #1;
               rr = ($urandom_range(0, 3) != 0);
            end
            rr = 1'b1;
         end
      join
      wait_drain();

      rr = 1'b0;
      send(0, 32'h40A00000, 32'h40A00000, 4'd1);
      send(0, 32'hC1200000, 32'h3F000000, 4'd2);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      chk("mid_valid", bus.resp_valid, 1);
      v[0] = 1'b1;
      v[1] = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.resp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready0", bus.req0_ready, 0);
      chk("mid_rst_ready1", bus.req1_ready, 0);
      chk("mid_rst_count", op_count, 0);
      chk("mid_rst_out", {bus.resp_result, bus.resp_port,
                          bus.resp_tag, bus.resp_special}, 0);
      v[0] = 1'b0;
      v[1] = 1'b0;
      exp_q.delete();
      done_cnt = '0;
      tb_prio = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rr = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_quiet", bus.resp_valid, 0);
      end

      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_cnt = '0;
      tb_prio = 0;
      fork
         send(0, 32'h3F800000, 32'h40000000, 4'd4);
         send(1, 32'h40400000, 32'h40400000, 4'd6);
         begin
            @(negedge clk);
            chk("first_gnt0", bus.req0_ready, 1);
            chk("first_gnt1", bus.req1_ready, 0);
         end
      join
      wait_drain();

      nfill = 65535 - int'(done_cnt);
      stream(0, nfill, 0);
      wait_drain();
      chk("wrap_ffff", op_count, 16'hFFFF);
      send(1, rand_op(), rand_op(), 4'd8);
      wait_drain();
      chk("wrap_zero", op_count, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fp_mult_scheduler.md
# fp_mult_scheduler

Shares one combinational single-precision multiplier core (`normal_mult`) between two requesters. Arbitration is round-robin; a 2-stage registered pipeline wraps the core with valid/ready handshakes on both sides. Zero operands bypass the core, and infinity/NaN operands are flagged to the consumer. The block sits between the FPU issue logic and the result writeback path, and returns each result with the originating port and tag.

## Interface
- `TAG_W`, default 4: width of the requester tag carried alongside each operation.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester has an operation.
- `req0_ready`, `req1_ready`  out  1  operation accepted this cycle (grant).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  IEEE-754 single operands.
- `req0_tag`, `req1_tag`  in  TAG_W  opaque ID, returned unchanged.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_result`  out  32  product.
- `resp_port`  out  1  originating requester, 0 or 1.
- `resp_tag`  out  TAG_W  tag of the originating operation.
- `resp_special`  out  1  either operand had exponent 8'hFF.
- `busy`  out  1  any pipeline stage holds a valid entry.
- `op_count`  out  16  count of completed responses.

## Operation
- **Stage S1 (operand register).** Holds `s1_valid`, operands, port and tag.
  - Enable: `s1_adv = !s1_valid || s2_adv`.
- **Stage S2 (output register).** Drives all `resp_*` outputs.
  - Enable: `s2_adv = !resp_valid || resp_ready`.
  - On enable: loads the S1 entry processed through the core, or clears `resp_valid` if S1 is empty.
- **Arbitration.** Combinational, and only when `s1_adv = 1`.
  - One valid requester: it is granted.
  - Both valid: the requester named by the priority pointer `prio` is granted.
  - `prio` toggles to the non-granted port after each contested grant. It is unchanged on an uncontested grant or when there is no grant.
  - `reqN_ready = grantN`. At most one ready is high per cycle.
  - `ready` may depend combinationally on `valid`. Requesters must not make `valid` depend on `ready`.
- **Handshake rules.**
  - A requester holds `valid` and its operands stable until `ready`.
  - A held `resp_valid` keeps all `resp_*` outputs stable until `resp_ready`.
- **Datapath in S1→S2.**
  - If either operand exponent is 8'h00, the result is `{a[31]^b[31], 31'b0}` and the core output is ignored.
  - Otherwise the result is the core output unchanged: truncation, no rounding, no overflow/underflow detection.
  - `resp_special = (a[30:23]==8'hFF) || (b[30:23]==8'hFF)`. This is evaluated before the zero check. The result is still produced by the rules above.
- **Counters and status.**
  - `op_count` increments on each `resp_valid && resp_ready`. It wraps from 16'hFFFF to 0.
  - `busy = s1_valid || resp_valid`.
- **Reset (async, `rst_n` low).** Applies immediately, including mid-operation; in-flight operations are discarded.
  - All valids = 0, `prio` = 0, `op_count` = 0.
  - `resp_result`, `resp_tag`, `resp_port` and `resp_special` = 0.
  - `req*_ready` = 0 while `rst_n` is low.

## Timing
- **Latency.** An operation accepted at rising edge k is registered in S1 at edge k and presented in S2 at edge k+1. `resp_valid` is high in the cycle after edge k+1, i.e. 2 cycles from the grant cycle to the response cycle.
- **Throughput.** 1 operation per cycle with `resp_ready` held high.
- **Backpressure.**
  - `resp_ready` low with S2 full: S2 holds. S1 can still fill if it is empty, giving a maximum of 2 in flight.
  - Once both stages are full, both `req_ready` stay low.
- **Simultaneous events.**
  - S2 draining (`resp_ready`) and S1 moving into S2 in the same cycle is legal.
  - A new grant into S1 in that same cycle is legal; there are no bubbles.
- **First cycle after reset release.** Both requesters valid → port 0 is granted.

## Test plan
- **Single multiply.** Port 0 sends a=0x40000000 (2.0), b=0x40400000 (3.0), tag=3 → 2 cycles later `resp_result`=0x40C00000, `resp_port`=0, `resp_tag`=3, `resp_special`=0, then `op_count`=1.
- **Normalization carry.** Port 1 sends 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000, `resp_port`=1.
- **Contention fairness.** Both ports valid continuously for 8 cycles, `resp_ready`=1 → grants alternate 0,1,0,1,…, 8 responses back-to-back with `resp_port` alternating.
- **Zero and special.**
  - 0x00000000 × 0xC0000000 → 0x80000000.
  - 0x7F800000 × 0x3F800000 → `resp_special`=1.
- **Backpressure.** `resp_ready`=0 while port 0 streams 4 ops → exactly 2 accepted. Outputs stay stable while held. After `resp_ready`=1, results drain in order with no loss or duplication.
- **Reset mid-flight and wrap.**
  - Assert `rst_n`=0 with 2 ops in flight → `resp_valid`=0 and `busy`=0 immediately, with no responses after release.
  - Preload traffic to `op_count`=16'hFFFF, then one more response → 0.
